// File: rtl/seven_seg_scan_ctrl.sv
// Multiplexed seven-segment scanner with frame-synchronous double buffering,
// leading-zero blanking, decimal points, per-digit blink and anti-ghost dead time.
module seven_seg_scan_ctrl #(
    parameter int NUM_DIGITS     = 4,
    parameter int REFRESH_DIV    = 16384,
    parameter int GHOST_CYCLES   = 64,
    parameter int BLINK_FRAMES   = 32,
    parameter int HEX_MODE       = 0,
    parameter int SEG_ACTIVE_LOW = 1,
    parameter int AN_ACTIVE_LOW  = 1
) (
    input  logic                    clk,
    input  logic                    reset_n,
    input  logic [4*NUM_DIGITS-1:0] value,
    input  logic                    load,
    input  logic [NUM_DIGITS-1:0]   dp_in,
    input  logic                    blank_zeros,
    input  logic [NUM_DIGITS-1:0]   blink_mask,
    output logic [6:0]              seg,
    output logic [NUM_DIGITS-1:0]   an,
    output logic                    dp,
    output logic                    frame_done
);

    localparam int SLOT_W = (REFRESH_DIV > 1) ? $clog2(REFRESH_DIV) : 1;
    localparam int IDX_W  = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;
    localparam int BLK_W  = $clog2(BLINK_FRAMES + 1);

    localparam logic [SLOT_W-1:0] SLOT_LAST = SLOT_W'(REFRESH_DIV - 1);
    localparam logic [SLOT_W-1:0] GHOST_END = SLOT_W'(GHOST_CYCLES);
    localparam logic [IDX_W-1:0]  IDX_LAST  = IDX_W'(NUM_DIGITS - 1);
    localparam logic [BLK_W-1:0]  BLK_LAST  = BLK_W'(BLINK_FRAMES - 1);

    localparam logic [6:0]            SEG_OFF = (SEG_ACTIVE_LOW != 0) ? 7'h7F : 7'h00;
    localparam logic                  DP_OFF  = (SEG_ACTIVE_LOW != 0) ? 1'b1 : 1'b0;
    localparam logic [NUM_DIGITS-1:0] AN_OFF  = (AN_ACTIVE_LOW != 0) ? '1 : '0;

    // Active-high glyphs, bit order {g,f,e,d,c,b,a}.
    function automatic logic [6:0] decode(input logic [3:0] code);
        logic [6:0] g;
        g = 7'h00;
        case (code)
            4'h0: g = 7'h3F;
            4'h1: g = 7'h06;
            4'h2: g = 7'h5B;
            4'h3: g = 7'h4F;
            4'h4: g = 7'h66;
            4'h5: g = 7'h6D;
            4'h6: g = 7'h7D;
            4'h7: g = 7'h07;
            4'h8: g = 7'h7F;
            4'h9: g = 7'h6F;
            4'hA: g = 7'h77;
            4'hB: g = 7'h7C;
            4'hC: g = 7'h39;
            4'hD: g = 7'h5E;
            4'hE: g = 7'h79;
            4'hF: g = 7'h71;
        endcase
        if ((HEX_MODE == 0) && (code > 4'd9)) begin
            g = 7'h00;
        end
        return g;
    endfunction

    function automatic logic [6:0] seg_pol(input logic [6:0] s);
        return (SEG_ACTIVE_LOW != 0) ? ~s : s;
    endfunction

    function automatic logic dp_pol(input logic d);
        return (SEG_ACTIVE_LOW != 0) ? ~d : d;
    endfunction

    function automatic logic [NUM_DIGITS-1:0] an_pol(input logic [NUM_DIGITS-1:0] a);
        return (AN_ACTIVE_LOW != 0) ? ~a : a;
    endfunction

    logic [SLOT_W-1:0]       slot_q, slot_d;
    logic [IDX_W-1:0]        idx_q, idx_d;
    logic [BLK_W-1:0]        blink_cnt_q, blink_cnt_d;
    logic                    blink_off_q, blink_off_d;
    logic [4*NUM_DIGITS-1:0] disp_val_q, disp_val_d;
    logic [NUM_DIGITS-1:0]   disp_dp_q, disp_dp_d;
    logic [4*NUM_DIGITS-1:0] pend_val_q, pend_val_d;
    logic [NUM_DIGITS-1:0]   pend_dp_q, pend_dp_d;
    logic                    pend_vld_q, pend_vld_d;
    logic [NUM_DIGITS-1:0]   an_q;
    logic [6:0]              seg_q;
    logic                    dp_q;
    logic                    frame_done_q;

    logic                    slot_tc;
    logic                    frame_wrap;

    always_comb begin
        slot_tc     = (slot_q == SLOT_LAST);
        frame_wrap  = slot_tc && (idx_q == IDX_LAST);
        slot_d      = slot_tc ? '0 : slot_q + 1'b1;
        idx_d       = idx_q;
        blink_cnt_d = blink_cnt_q;
        blink_off_d = blink_off_q;
        if (slot_tc) begin
            idx_d = (idx_q == IDX_LAST) ? '0 : idx_q + 1'b1;
        end
        if (frame_wrap) begin
            if (blink_cnt_q == BLK_LAST) begin
                blink_cnt_d = '0;
                blink_off_d = ~blink_off_q;
            end else begin
                blink_cnt_d = blink_cnt_q + 1'b1;
            end
        end
    end

    // The display buffer only moves at the frame wrap; a load landing on the
    // wrap bypasses the pending buffer entirely.
    always_comb begin
        disp_val_d = disp_val_q;
        disp_dp_d  = disp_dp_q;
        pend_val_d = pend_val_q;
        pend_dp_d  = pend_dp_q;
        pend_vld_d = pend_vld_q;
        if (frame_wrap) begin
            if (load) begin
                disp_val_d = value;
                disp_dp_d  = dp_in;
            end else if (pend_vld_q) begin
                disp_val_d = pend_val_q;
                disp_dp_d  = pend_dp_q;
            end
            pend_vld_d = 1'b0;
        end else if (load) begin
            pend_val_d = value;
            pend_dp_d  = dp_in;
            pend_vld_d = 1'b1;
        end
    end

    logic [NUM_DIGITS-1:0]   zero_blank;
    logic                    lead_zero;
    logic [3:0]              cur_nib;
    logic                    cur_dp;
    logic                    cur_blank;
    logic                    cur_hide;

    always_comb begin
        zero_blank = '0;
        lead_zero  = blank_zeros;
        for (int i = NUM_DIGITS - 1; i >= 1; i--) begin
            lead_zero     = lead_zero && (disp_val_q[4*i +: 4] == 4'h0);
            zero_blank[i] = lead_zero;
        end
        cur_nib   = 4'h0;
        cur_dp    = 1'b0;
        cur_blank = 1'b0;
        cur_hide  = 1'b0;
        for (int i = 0; i < NUM_DIGITS; i++) begin
            if (idx_q == IDX_W'(i)) begin
                cur_nib   = disp_val_q[4*i +: 4];
                cur_dp    = disp_dp_q[i];
                cur_blank = zero_blank[i];
                cur_hide  = blink_off_q && blink_mask[i];
            end
        end
    end

    logic [NUM_DIGITS-1:0]   an_act;
    logic [6:0]              seg_act;
    logic                    dp_act;

    always_comb begin
        an_act  = '0;
        seg_act = 7'h00;
        dp_act  = 1'b0;
        if (slot_q >= GHOST_END) begin
            for (int i = 0; i < NUM_DIGITS; i++) begin
                an_act[i] = (idx_q == IDX_W'(i)) && !cur_hide;
            end
            seg_act = cur_blank ? 7'h00 : decode(cur_nib);
            dp_act  = cur_dp;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            slot_q       <= '0;
            idx_q        <= '0;
            blink_cnt_q  <= '0;
            blink_off_q  <= 1'b0;
            disp_val_q   <= '0;
            disp_dp_q    <= '0;
            pend_val_q   <= '0;
            pend_dp_q    <= '0;
            pend_vld_q   <= 1'b0;
            an_q         <= AN_OFF;
            seg_q        <= SEG_OFF;
            dp_q         <= DP_OFF;
            frame_done_q <= 1'b0;
        end else begin
            slot_q       <= slot_d;
            idx_q        <= idx_d;
            blink_cnt_q  <= blink_cnt_d;
            blink_off_q  <= blink_off_d;
            disp_val_q   <= disp_val_d;
            disp_dp_q    <= disp_dp_d;
            pend_val_q   <= pend_val_d;
            pend_dp_q    <= pend_dp_d;
            pend_vld_q   <= pend_vld_d;
            an_q         <= an_pol(an_act);
            seg_q        <= seg_pol(seg_act);
            dp_q         <= dp_pol(dp_act);
            frame_done_q <= frame_wrap;
        end
    end

    assign an         = an_q;
    assign seg        = seg_q;
    assign dp         = dp_q;
    assign frame_done = frame_done_q;

endmodule

// File: tb/tb_seven_seg_scan_ctrl.sv
// Scoreboard bench for seven_seg_scan_ctrl: two instances (HEX_MODE 0 and 1)
// share stimulus; expected per-cycle outputs are queued and checked by a monitor.
module tb_seven_seg_scan_ctrl;

    logic        clk = 1'b0;
    logic        reset_n = 1'b0;
    logic [15:0] value = 16'h0;
    logic        load = 1'b0;
    logic [3:0]  dp_in = 4'h0;
    logic        blank_zeros = 1'b0;
    logic [3:0]  blink_mask = 4'h0;

    logic [6:0]  seg0, seg1;
    logic [3:0]  an0, an1;
    logic        dp0, dp1, fd0, fd1;

    always #5 clk = ~clk;

    seven_seg_scan_ctrl #(
        .NUM_DIGITS(4), .REFRESH_DIV(8), .GHOST_CYCLES(2), .BLINK_FRAMES(2),
        .HEX_MODE(0), .SEG_ACTIVE_LOW(1), .AN_ACTIVE_LOW(1)
    ) dut_h0 (
        .clk(clk), .reset_n(reset_n), .value(value), .load(load), .dp_in(dp_in),
        .blank_zeros(blank_zeros), .blink_mask(blink_mask),
        .seg(seg0), .an(an0), .dp(dp0), .frame_done(fd0)
    );

    seven_seg_scan_ctrl #(
        .NUM_DIGITS(4), .REFRESH_DIV(8), .GHOST_CYCLES(2), .BLINK_FRAMES(2),
        .HEX_MODE(1), .SEG_ACTIVE_LOW(1), .AN_ACTIVE_LOW(1)
    ) dut_h1 (
        .clk(clk), .reset_n(reset_n), .value(value), .load(load), .dp_in(dp_in),
        .blank_zeros(blank_zeros), .blink_mask(blink_mask),
        .seg(seg1), .an(an1), .dp(dp1), .frame_done(fd1)
    );

    // Active-low glyphs {g,f,e,d,c,b,a}
    localparam logic [6:0] G0 = 7'b1000000;
    localparam logic [6:0] G1 = 7'b1111001;
    localparam logic [6:0] G2 = 7'b0100100;
    localparam logic [6:0] G3 = 7'b0110000;
    localparam logic [6:0] G4 = 7'b0011001;
    localparam logic [6:0] G6 = 7'b0000010;
    localparam logic [6:0] G7 = 7'b1111000;
    localparam logic [6:0] G8 = 7'b0000000;
    localparam logic [6:0] G9 = 7'b0010000;
    localparam logic [6:0] GA = 7'b0001000;
    localparam logic [6:0] GF = 7'b0001110;
    localparam logic [6:0] BL = 7'b1111111;

    localparam logic [12:0] RST_EXP = 13'b1111_1111111_1_0;

    typedef struct {
        int          n;
        logic [12:0] e0;
        logic [12:0] e1;
        logic [12:0] m;
    } exp_t;

    exp_t q[$];
    exp_t mon_it;
    int   total = 0;
    int   bad = 0;
    int   n = 0;

    // Posedges since the last reset release.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) n <= 0;
        else          n <= n + 1;
    end

    task automatic chk(input string name, input int cyc, input logic [12:0] act, input logic [12:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s n=%0d got {an,seg,dp,fd}=%b want=%b", name, cyc, act, exp);
        end
    endtask

    always @(negedge clk) begin
        while (q.size() > 0 && q[0].n <= n) begin
            mon_it = q.pop_front();
            if (mon_it.n < n) begin
                total++;
                bad++;
                $display("FAIL missed_sample n=%0d got cycle=%0d", mon_it.n, n);
            end else begin
                chk("hex0_out", n, {an0, seg0, dp0, fd0} & mon_it.m, mon_it.e0 & mon_it.m);
                chk("hex1_out", n, {an1, seg1, dp1, fd1} & mon_it.m, mon_it.e1 & mon_it.m);
            end
        end
    end

    // Frame m covers samples n = 32m+1 .. 32m+32; each digit slot is 2 dead + 6 lit cycles.
    task automatic push_frame(input int m, input logic [27:0] sa, input logic [27:0] sb,
                              input logic [3:0] dpv, input logic [3:0] off);
        exp_t       it;
        logic       act;
        logic [3:0] an_e;
        logic [6:0] sa_e, sb_e;
        logic       dp_e, fd_e;
        for (int d = 0; d < 4; d++) begin
            for (int s = 0; s < 8; s++) begin
                act  = (s >= 2);
                an_e = (act && !off[d]) ? ~(4'b0001 << d) : 4'b1111;
                sa_e = act ? sa[7*d +: 7] : BL;
                sb_e = act ? sb[7*d +: 7] : BL;
                dp_e = act ? ~dpv[d] : 1'b1;
                fd_e = (d == 3) && (s == 7);
                it.n  = 32*m + 8*d + s + 1;
                it.e0 = {an_e, sa_e, dp_e, fd_e};
                it.e1 = {an_e, sb_e, dp_e, fd_e};
                it.m  = off[d] ? 13'b1111_0000000_0_1 : 13'h1FFF;
                q.push_back(it);
            end
        end
    endtask

    task automatic wait_n(input int k);
        while (n < k) @(negedge clk);
    endtask

    task automatic do_load(input int p, input logic [15:0] v, input logic [3:0] d);
        wait_n(p - 1);
        value = v;
        dp_in = d;
        load  = 1'b1;
        @(negedge clk);
        load  = 1'b0;
    endtask

    initial begin
        #50000;
        $display("FAIL watchdog n=%0d queue=%0d", n, q.size());
        $fatal(1, "watchdog");
    end

    initial begin
        #12;
        chk("reset_h0", n, {an0, seg0, dp0, fd0}, RST_EXP);
        chk("reset_h1", n, {an1, seg1, dp1, fd1}, RST_EXP);
        @(negedge clk);
        reset_n = 1'b1;

        push_frame(0, {G0, G0, G0, G0}, {G0, G0, G0, G0}, 4'b0000, 4'b0000);
        do_load(5, 16'h1234, 4'b0000);
        push_frame(1, {G1, G2, G3, G4}, {G1, G2, G3, G4}, 4'b0000, 4'b0000);

        wait_n(39);
        blank_zeros = 1'b1;
        do_load(40, 16'h0042, 4'b0100);
        push_frame(2, {BL, BL, G4, G2}, {BL, BL, G4, G2}, 4'b0100, 4'b0000);

        do_load(72, 16'h0000, 4'b0000);
        push_frame(3, {BL, BL, BL, G0}, {BL, BL, BL, G0}, 4'b0000, 4'b0000);

        do_load(100, 16'h5555, 4'b0000);
        do_load(110, 16'h6666, 4'b0000);
        push_frame(4, {G6, G6, G6, G6}, {G6, G6, G6, G6}, 4'b0000, 4'b0000);

        wait_n(130);
        blank_zeros = 1'b0;
        do_load(160, 16'h7089, 4'b0000);
        push_frame(5, {G7, G0, G8, G9}, {G7, G0, G8, G9}, 4'b0000, 4'b0000);

        wait_n(170);
        blink_mask = 4'b0001;
        push_frame(6, {G7, G0, G8, G9}, {G7, G0, G8, G9}, 4'b0000, 4'b0001);
        push_frame(7, {G7, G0, G8, G9}, {G7, G0, G8, G9}, 4'b0000, 4'b0001);
        push_frame(8, {G7, G0, G8, G9}, {G7, G0, G8, G9}, 4'b0000, 4'b0000);
        push_frame(9, {G7, G0, G8, G9}, {G7, G0, G8, G9}, 4'b0000, 4'b0000);

        do_load(300, 16'hA0F9, 4'b0000);
        wait_n(310);
        blink_mask = 4'b0000;
        push_frame(10, {BL, G0, BL, G9}, {GA, G0, GF, G9}, 4'b0000, 4'b0000);

        wait_n(360);
        #3;
        reset_n    = 1'b0;
        blink_mask = 4'b0001;
        #1;
        chk("async_rst_h0", n, {an0, seg0, dp0, fd0}, RST_EXP);
        chk("async_rst_h1", n, {an1, seg1, dp1, fd1}, RST_EXP);
        @(negedge clk);
        @(negedge clk);
        chk("held_rst_h0", n, {an0, seg0, dp0, fd0}, RST_EXP);
        reset_n = 1'b1;
        push_frame(0, {G0, G0, G0, G0}, {G0, G0, G0, G0}, 4'b0000, 4'b0000);
        wait_n(34);

        while (q.size() > 0) begin
            mon_it = q.pop_front();
            total++;
            bad++;
            $display("FAIL unchecked_sample n=%0d got none", mon_it.n);
        end
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
